// File: rtl/pbit_field_accum.sv
// Local field z = bias + sum_j J_j*(spin_j ? +1 : -1), weights streamed from a sync RAM, result saturated to 8.24.
// Latency N_SPINS+2 edges from accepted start to z_valid; no backpressure, start is ignored while busy.
module pbit_field_accum #(
    parameter int N_SPINS    = 16,
    parameter int IDX_W      = 4,
    parameter int INT_SIZE   = 8,
    parameter int FLOAT_SIZE = 24
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           start,
    input  logic [N_SPINS-1:0]             spins,
    input  logic [INT_SIZE+FLOAT_SIZE-1:0] bias,
    output logic                           w_rd_en,
    output logic [IDX_W-1:0]               w_addr,
    input  logic [INT_SIZE+FLOAT_SIZE-1:0] w_rd_data,
    output logic                           busy,
    output logic [INT_SIZE+FLOAT_SIZE-1:0] z,
    output logic                           z_valid
);
    localparam int W     = INT_SIZE + FLOAT_SIZE;
    localparam int ACC_W = W + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPINS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(IDX_W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(IDX_W+2){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [N_SPINS-1:0]       snap_q, snap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     w_rd_en_q, w_rd_en_d;
    logic [IDX_W-1:0]         w_addr_q, w_addr_d;
    logic                     busy_q, busy_d;
    logic [W-1:0]             z_q, z_d;
    logic                     z_valid_q, z_valid_d;
    // Index of the weight currently on w_rd_data, one cycle behind the RAM request.
    logic                     p_vld_q, p_vld_d;
    logic [IDX_W-1:0]         p_idx_q, p_idx_d;

    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic [W-1:0]             acc_sat;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            acc_q     <= '0;
            w_rd_en_q <= 1'b0;
            w_addr_q  <= '0;
            busy_q    <= 1'b0;
            z_q       <= '0;
            z_valid_q <= 1'b0;
            p_vld_q   <= 1'b0;
            p_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            acc_q     <= acc_d;
            w_rd_en_q <= w_rd_en_d;
            w_addr_q  <= w_addr_d;
            busy_q    <= busy_d;
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            p_vld_q   <= p_vld_d;
            p_idx_q   <= p_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (w_addr_q == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN: if (p_vld_q && (p_idx_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign w_ext    = {{(IDX_W+1){w_rd_data[W-1]}}, w_rd_data};
    assign bias_ext = {{(IDX_W+1){bias[W-1]}}, bias};

    always_comb begin
        if (acc_q > ACC_MAX)      acc_sat = {1'b0, {(W-1){1'b1}}};
        else if (acc_q < ACC_MIN) acc_sat = {1'b1, {(W-1){1'b0}}};
        else                      acc_sat = acc_q[W-1:0];
    end

    always_comb begin
        snap_d    = snap_q;
        acc_d     = acc_q;
        w_rd_en_d = w_rd_en_q;
        w_addr_d  = w_addr_q;
        busy_d    = busy_q;
        z_d       = z_q;
        z_valid_d = 1'b0;
        p_vld_d   = w_rd_en_q;
        p_idx_d   = w_addr_q;

        if (p_vld_q) begin
            if (snap_q[p_idx_q]) acc_d = acc_q + w_ext;
            else                 acc_d = acc_q - w_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d    = spins;
                    acc_d     = bias_ext;
                    w_addr_d  = '0;
                    w_rd_en_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_FETCH: begin
                if (w_addr_q == LAST_IDX) w_rd_en_d = 1'b0;
                else                      w_addr_d  = w_addr_q + IDX_W'(1);
            end
            S_DONE: begin
                z_d       = acc_sat;
                z_valid_d = 1'b1;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_rd_en = w_rd_en_q;
    assign w_addr  = w_addr_q;
    assign busy    = busy_q;
    assign z       = z_q;
    assign z_valid = z_valid_q;
endmodule

// File: tb/tb_pbit_field_accum.sv
// Scoreboard bench for pbit_field_accum: expected fields are pushed on accepted start and popped on z_valid.
module tb_pbit_field_accum;
    localparam int N = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] spins = '0;
    logic [31:0] bias = '0;
    logic        w_rd_en;
    logic [3:0]  w_addr;
    logic [31:0] w_rd_data = '0;
    logic        busy;
    logic [31:0] z;
    logic        z_valid;

    logic [31:0] ram [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_start = 0;
    bit run_valid = 1'b0;
    int free_at = 0;

    typedef struct {
        logic [31:0] z;
        int          cyc;
    } exp_t;
    exp_t q[$];

    pbit_field_accum #(.N_SPINS(16), .IDX_W(4), .INT_SIZE(8), .FLOAT_SIZE(24)) dut (
        .CLK(CLK), .RST(RST), .start(start), .spins(spins), .bias(bias),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
        .busy(busy), .z(z), .z_valid(z_valid)
    );

    always #5 CLK = ~CLK;

    // Synchronous weight RAM: data appears the cycle after the request edge.
    always @(posedge CLK) if (w_rd_en) w_rd_data <= ram[w_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_z(input logic [15:0] s, input logic [31:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int j = 0; j < N; j++) begin
            if (s[j]) acc = acc + longint'($signed(ram[j]));
            else      acc = acc - longint'($signed(ram[j]));
        end
        if (acc > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (acc < -64'sd2147483648) return 32'h80000000;
        return acc[31:0];
    endfunction

    task automatic tick();
        bit          s;
        logic [15:0] sp;
        logic [31:0] b;
        s  = start;
        sp = spins;
        b  = bias;
        @(posedge CLK);
        cyc++;
        if (s && !RST && cyc >= free_at) begin
            q.push_back('{model_z(sp, b), cyc + N + 2});
            run_start = cyc;
            run_valid = 1'b1;
            free_at   = cyc + N + 3;
        end
        #1;
    endtask

    task automatic set_ram(input logic [31:0] v);
        for (int j = 0; j < N; j++) ram[j] = v;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic [15:0] sp, input logic [31:0] b);
        spins = sp;
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N + 4) tick();
        drain();
    endtask

    always @(negedge CLK) begin
        int   d;
        exp_t e;
        if (!RST) begin
            d = cyc - run_start;
            if (run_valid && d <= N + 1) begin
                chk("busy_active", {31'd0, busy}, 32'd1);
                chk("w_rd_en", {31'd0, w_rd_en}, (d < N) ? 32'd1 : 32'd0);
                chk("w_addr", {28'd0, w_addr}, (d < N) ? 32'(d) : 32'(N - 1));
            end else begin
                chk("busy_idle", {31'd0, busy}, 32'd0);
                chk("w_rd_en_idle", {31'd0, w_rd_en}, 32'd0);
            end
            if (z_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_z_valid: got z_valid=1 z=%h, required no pulse", z);
                end else begin
                    e = q.pop_front();
                    chk("z", z, e.z);
                    chk("z_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic [31:0] tmp;
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_w_rd_en", {31'd0, w_rd_en}, 32'd0);
        chk("rst_w_addr", {28'd0, w_addr}, 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_z_valid", {31'd0, z_valid}, 32'd0);
        RST = 1'b0;
        tick();

        set_ram(32'h01000000);
        run(16'hFFFF, 32'h0);
        chk("t1_z_16", z, 32'h10000000);
        run(16'h0000, 32'h00800000);
        chk("t2_z_m15p5", z, 32'hF0800000);

        set_ram(32'h7F000000);
        run(16'hFFFF, 32'h0);
        chk("t3_sat_pos", z, 32'h7FFFFFFF);
        run(16'h0000, 32'h0);
        chk("t3_sat_neg", z, 32'h80000000);

        // Spins change and a second start mid-run must not disturb the run in flight.
        set_ram(32'h01000000);
        spins = 16'hAAAA;
        bias  = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        spins = 16'hFFFF;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N) tick();
        drain();
        chk("t4_z_zero", z, 32'h0);

        spins = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_w_rd_en", {31'd0, w_rd_en}, 32'd0);
        chk("mid_rst_w_addr", {28'd0, w_addr}, 32'd0);
        chk("mid_rst_z", z, 32'd0);
        chk("mid_rst_z_valid", {31'd0, z_valid}, 32'd0);
        q.delete();
        run_valid = 1'b0;
        free_at   = 0;
        repeat (2) tick();
        RST = 1'b0;
        repeat (N + 4) tick();
        run(16'hFFFF, 32'h0);
        chk("t5_z_after_rst", z, 32'h10000000);

        // start held high: runs every N+3 edges, each capturing its own operands.
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            spins = 16'($urandom);
            bias  = $urandom;
            tick();
        end
        start = 1'b0;
        drain();

        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < N; j++) begin
                tmp = $urandom;
                ram[j] = (r % 2 == 0) ? {{5{tmp[31]}}, tmp[31:5]} : tmp;
            end
            run(16'($urandom), $urandom);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
